// File: rtl/go_cursor_ctrl_pkg.sv
// Shared types and helpers for the Go player input front-end: cell encoding,
// cursor directions, UI states and the flat-board cell accessor.
package go_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BLACK = 2'b01,
    WHITE = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    LOCKED = 3'd0,
    IDLE   = 3'd1,
    SEEK   = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } ui_state_t;

  // All-ones move code; users slice off the 2*COORD_W bits they need.
  localparam logic [31:0] PASS_CODE = '1;

  // Widest board the accessor supports (19x19).
  localparam int BOARD_BITS_MAX = 2 * 19 * 19;

  function automatic logic [1:0] cell_at(input logic [BOARD_BITS_MAX-1:0] b,
                                         input int n, input int r, input int c);
    return b[2*(r*n+c) +: 2];
  endfunction

endpackage

// File: rtl/go_cursor_ctrl_btn_edge.sv
// Two-stage input register with rising-edge detect; a held level yields a
// single one-cycle event.
module btn_edge #(
  parameter int W = 6
) (
  input  logic         clk_in,
  input  logic         reset,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] btn_q;
  logic [W-1:0] btn_d;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      btn_q <= '0;
      btn_d <= '0;
    end else begin
      btn_q <= level;
      btn_d <= btn_q;
    end
  end

  assign rise = btn_q & ~btn_d;

endmodule

// File: rtl/go_cursor_ctrl.sv
// Board cursor controller: turns button events into cursor moves that park on
// empty intersections, and issues one move or pass per turn.
module go_cursor_ctrl
  import go_pkg::*;
#(
  parameter int BOARD_N = 9,
  parameter int COORD_W = 4,
  parameter int WRAP    = 1
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         my_turn,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         make_move,
  input  logic                         pass_btn,
  input  logic [2*BOARD_N*BOARD_N-1:0] board,
  output logic                         locked,
  output logic                         move_ready,
  output logic [2*COORD_W-1:0]         move_out,
  output logic                         is_pass,
  output logic [2*COORD_W-1:0]         cursor,
  output logic                         cursor_valid
);

  localparam logic [COORD_W-1:0] MAX_C  = COORD_W'(BOARD_N - 1);
  localparam logic [COORD_W-1:0] CENTER = COORD_W'(BOARD_N / 2);

  logic [5:0]                rise;
  logic [BOARD_BITS_MAX-1:0] board_ext;
  logic [COORD_W-1:0]        cur_r, cur_c;

  ui_state_t            state, state_nxt;
  dir_t                 seek_dir, dir_nxt, req_dir;
  logic [2*COORD_W-1:0] seek_start, start_nxt, cursor_nxt, move_nxt;
  logic [COORD_W-1:0]   step_cnt, cnt_nxt;
  logic                 pass_nxt, ready_nxt, start_seek;

  // Priority order of the bits is pass, make_move, up, down, left, right.
  btn_edge #(.W(6)) u_btn_edge (
    .clk_in (clk_in),
    .reset  (reset),
    .level  ({pass_btn, make_move, up, down, left, right}),
    .rise   (rise)
  );

  function automatic logic can_step(input dir_t d, input logic [COORD_W-1:0] r,
                                    input logic [COORD_W-1:0] c);
    if (WRAP != 0) return 1'b1;
    case (d)
      UP:      return r != '0;
      DOWN:    return r != MAX_C;
      LEFT:    return c != '0;
      default: return c != MAX_C;
    endcase
  endfunction

  function automatic logic [2*COORD_W-1:0] step_pos(input dir_t d,
                                                    input logic [COORD_W-1:0] r,
                                                    input logic [COORD_W-1:0] c);
    logic [COORD_W-1:0] nr, nc;
    nr = r;
    nc = c;
    case (d)
      UP:      nr = (r == '0)    ? MAX_C : r - 1'b1;
      DOWN:    nr = (r == MAX_C) ? '0    : r + 1'b1;
      LEFT:    nc = (c == '0)    ? MAX_C : c - 1'b1;
      default: nc = (c == MAX_C) ? '0    : c + 1'b1;
    endcase
    return {nr, nc};
  endfunction

  assign board_ext    = BOARD_BITS_MAX'(board);
  assign cur_r        = cursor[2*COORD_W-1:COORD_W];
  assign cur_c        = cursor[COORD_W-1:0];
  assign cursor_valid = (cell_at(board_ext, BOARD_N, int'(cur_r), int'(cur_c)) == EMPTY);
  assign locked       = (state == LOCKED) || (state == DONE);

  always_comb begin
    state_nxt  = state;
    cursor_nxt = cursor;
    start_nxt  = seek_start;
    dir_nxt    = seek_dir;
    cnt_nxt    = step_cnt;
    move_nxt   = move_out;
    pass_nxt   = is_pass;
    ready_nxt  = (state == COMMIT);
    start_seek = 1'b0;
    req_dir    = RIGHT;
    case (state)
      LOCKED: begin
        if (my_turn) begin
          if (cursor_valid) state_nxt = IDLE;
          else              start_seek = 1'b1;
        end
      end
      IDLE: begin
        if (!my_turn) begin
          state_nxt = LOCKED;
        end else if (rise[5]) begin
          state_nxt = COMMIT;
          move_nxt  = PASS_CODE[2*COORD_W-1:0];
          pass_nxt  = 1'b1;
        end else if (rise[4]) begin
          if (cursor_valid) begin
            state_nxt = COMMIT;
            move_nxt  = cursor;
            pass_nxt  = 1'b0;
          end
        end else if (|rise[3:0]) begin
          start_seek = 1'b1;
          req_dir    = rise[3] ? UP : rise[2] ? DOWN : rise[1] ? LEFT : RIGHT;
        end
      end
      SEEK: begin
        if (!my_turn) begin
          state_nxt  = LOCKED;
          cursor_nxt = seek_start;
        end else if (cursor_valid) begin
          state_nxt = IDLE;
        end else if (!can_step(seek_dir, cur_r, cur_c) || step_cnt == MAX_C) begin
          // No empty cell reachable along this line: give up where we began.
          state_nxt  = IDLE;
          cursor_nxt = seek_start;
        end else begin
          cursor_nxt = step_pos(seek_dir, cur_r, cur_c);
          cnt_nxt    = step_cnt + 1'b1;
        end
      end
      COMMIT:  state_nxt = DONE;
      DONE:    if (!my_turn) state_nxt = LOCKED;
      default: state_nxt = LOCKED;
    endcase
    if (start_seek) begin
      state_nxt = SEEK;
      dir_nxt   = req_dir;
      start_nxt = cursor;
      cnt_nxt   = '0;
      if (can_step(req_dir, cur_r, cur_c)) begin
        cursor_nxt = step_pos(req_dir, cur_r, cur_c);
        cnt_nxt    = COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= LOCKED;
      cursor     <= {CENTER, CENTER};
      seek_start <= {CENTER, CENTER};
      seek_dir   <= RIGHT;
      step_cnt   <= '0;
      move_out   <= '0;
      is_pass    <= 1'b0;
      move_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      cursor     <= cursor_nxt;
      seek_start <= start_nxt;
      seek_dir   <= dir_nxt;
      step_cnt   <= cnt_nxt;
      move_out   <= move_nxt;
      is_pass    <= pass_nxt;
      move_ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_go_cursor_ctrl.sv
// Directed bench for go_cursor_ctrl: a wrapping and a clamping instance share
// every input so edge behaviour can be compared side by side.
module tb_go_cursor_ctrl;

  localparam int N = 9;
  localparam int B_PASS = 5, B_MAKE = 4, B_UP = 3, B_RIGHT = 0, B_LEFT = 1;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             my_turn;
  logic [5:0]       btns;
  logic [2*N*N-1:0] board;

  logic       locked_w, ready_w, pass_w, valid_w;
  logic [7:0] move_w, cursor_w;
  logic       locked_c, ready_c, pass_c, valid_c;
  logic [7:0] move_c, cursor_c;

  int checks   = 0;
  int failures = 0;
  int pulses;

  always #5 clk_in = ~clk_in;

  go_cursor_ctrl #(.BOARD_N(N), .COORD_W(4), .WRAP(1)) dut (
    .clk_in(clk_in), .reset(reset), .my_turn(my_turn),
    .up(btns[3]), .down(btns[2]), .left(btns[1]), .right(btns[0]),
    .make_move(btns[4]), .pass_btn(btns[5]), .board(board),
    .locked(locked_w), .move_ready(ready_w), .move_out(move_w),
    .is_pass(pass_w), .cursor(cursor_w), .cursor_valid(valid_w)
  );

  go_cursor_ctrl #(.BOARD_N(N), .COORD_W(4), .WRAP(0)) dut_clamp (
    .clk_in(clk_in), .reset(reset), .my_turn(my_turn),
    .up(btns[3]), .down(btns[2]), .left(btns[1]), .right(btns[0]),
    .make_move(btns[4]), .pass_btn(btns[5]), .board(board),
    .locked(locked_c), .move_ready(ready_c), .move_out(move_c),
    .is_pass(pass_c), .cursor(cursor_c), .cursor_valid(valid_c)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse the given buttons for one sampling edge, then count move_ready
  // pulses of the wrapping instance over the following cycles.
  task automatic press(input logic [5:0] mask, output int cnt);
    cnt  = 0;
    btns = mask;
    tick(1);
    btns = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (ready_w) cnt++;
    end
  endtask

  function automatic int bi(input int r, input int c);
    return 2 * (r * N + c);
  endfunction

  initial begin
    reset   = 1'b1;
    my_turn = 1'b0;
    btns    = '0;
    board   = '0;
    tick(2);
    check("rst_locked", {7'd0, locked_w}, 8'd1);
    check("rst_cursor", cursor_w, 8'h44);
    check("rst_move_out", move_w, 8'h00);
    check("rst_ready", {7'd0, ready_w}, 8'd0);
    check("rst_is_pass", {7'd0, pass_w}, 8'd0);
    check("rst_valid", {7'd0, valid_w}, 8'd1);
    reset = 1'b0;

    // Plain commit at the centre, with exact pulse timing.
    my_turn = 1'b1;
    tick(1);
    check("idle_unlocked", {7'd0, locked_w}, 8'd0);
    btns[B_MAKE] = 1'b1;
    tick(1);
    btns = '0;
    check("commit_not_yet", {7'd0, ready_w}, 8'd0);
    tick(1);
    check("commit_lat_k1", {7'd0, ready_w}, 8'd0);
    check("commit_state_unlocked", {7'd0, locked_w}, 8'd0);
    tick(1);
    check("commit_pulse", {7'd0, ready_w}, 8'd1);
    check("commit_move", move_w, 8'h44);
    check("commit_not_pass", {7'd0, pass_w}, 8'd0);
    tick(1);
    check("commit_pulse_end", {7'd0, ready_w}, 8'd0);
    check("done_locked", {7'd0, locked_w}, 8'd1);
    press(6'b1 << B_MAKE, pulses);
    check("no_double_commit", 8'(pulses), 8'd0);
    my_turn = 1'b0;
    tick(1);

    // Seek across two occupied cells.
    board[bi(4, 5)] = 1'b1;
    board[bi(4, 6)] = 1'b1;
    my_turn = 1'b1;
    tick(1);
    btns[B_RIGHT] = 1'b1;
    tick(1);
    btns = '0;
    tick(1);
    check("seek_step1", cursor_w, 8'h45);
    tick(1);
    check("seek_step2", cursor_w, 8'h46);
    tick(1);
    check("seek_step3", cursor_w, 8'h47);
    tick(1);
    check("seek_settled", cursor_w, 8'h47);
    check("seek_settled_clamp", cursor_c, 8'h47);
    press(6'b1 << B_RIGHT, pulses);
    check("to_edge", cursor_w, 8'h48);
    press(6'b1 << B_RIGHT, pulses);
    check("wrap_right", cursor_w, 8'h40);
    check("clamp_right", cursor_c, 8'h48);

    // Back to the centre, then up to row 0.
    board   = '0;
    my_turn = 1'b0;
    reset   = 1'b1;
    tick(2);
    reset   = 1'b0;
    my_turn = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) press(6'b1 << B_UP, pulses);
    check("up_to_row0", cursor_w, 8'h04);
    check("up_to_row0_clamp", cursor_c, 8'h04);

    // Row 0 full except (0,4): wrapping search exhausts and restores.
    for (int c = 0; c < N; c++) if (c != 4) board[bi(0, c)] = 1'b1;
    btns[B_LEFT] = 1'b1;
    tick(1);
    btns = '0;
    tick(5);
    check("row_seek_wrapped", cursor_w, 8'h08);
    check("row_seek_clamp_restored", cursor_c, 8'h04);
    tick(3);
    check("row_seek_last_step", cursor_w, 8'h05);
    tick(1);
    check("row_seek_restored", cursor_w, 8'h04);
    check("row_seek_valid", {7'd0, valid_w}, 8'd1);

    // Full board: make_move is ignored, pass beats a simultaneous make_move.
    board = {(N*N){2'b01}};
    #1;
    check("full_invalid", {7'd0, valid_w}, 8'd0);
    press(6'b1 << B_MAKE, pulses);
    check("full_make_ignored", 8'(pulses), 8'd0);
    press((6'b1 << B_PASS) | (6'b1 << B_MAKE), pulses);
    check("pass_one_pulse", 8'(pulses), 8'd1);
    check("pass_move", move_w, 8'hFF);
    check("pass_flag", {7'd0, pass_w}, 8'd1);
    my_turn = 1'b0;
    tick(1);

    // Occupied cursor on turn start triggers a rightward seek.
    board = '0;
    board[bi(0, 4)] = 1'b1;
    board[bi(0, 5)] = 1'b1;
    my_turn = 1'b1;
    tick(1);
    check("entry_seek_step", cursor_w, 8'h05);
    tick(2);
    check("entry_seek_done", cursor_w, 8'h06);
    check("entry_seek_unlocked", {7'd0, locked_w}, 8'd0);

    // Turn ends mid-seek: cursor returns to the seek start.
    board[bi(0, 7)] = 1'b1;
    board[bi(0, 8)] = 1'b1;
    btns[B_RIGHT] = 1'b1;
    tick(1);
    btns = '0;
    tick(1);
    check("abort_seek_moving", cursor_w, 8'h07);
    my_turn = 1'b0;
    tick(1);
    check("abort_locked", {7'd0, locked_w}, 8'd1);
    check("abort_restored", cursor_w, 8'h06);
    check("abort_restored_clamp", cursor_c, 8'h06);
    check("move_held", move_w, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/go_cursor_ctrl.md
Name: go_cursor_ctrl

Overview:
- Parametrised successor to the player input front-end: turns debounced button levels into a board cursor that always parks on an empty intersection.
- Adds an explicit pass move, wrap or clamp edge modes, and a clean one-shot commit handshake.
- Sits between the debounced button/switch inputs and the game-state engine. It reads the live board and emits one move (or pass) per turn.

Parameters:
- BOARD_N, 9: board edge length; legal coordinates 0..BOARD_N-1.
- COORD_W, 4: bits per coordinate; must satisfy 2**COORD_W > BOARD_N.
- WRAP, 1: 1 = cursor wraps at edges; 0 = cursor clamps at edges.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high.
- my_turn  in  1  level; high while this player may move.
- up, down, left, right  in  1 each  debounced direction button levels.
- make_move  in  1  debounced commit button level.
- pass_btn  in  1  debounced pass button level.
- board  in  2*BOARD_N*BOARD_N  flat board; cell (r,c) at bits [2*(r*BOARD_N+c) +: 2]; 2'b00 = empty.
- locked  out  1  high when the block is not accepting input.
- move_ready  out  1  one-cycle pulse; move_out and is_pass are valid in that cycle.
- move_out  out  2*COORD_W  {row,col} of the committed move; all-ones (PASS_CODE) for a pass.
- is_pass  out  1  high with move_ready when the move is a pass.
- cursor  out  2*COORD_W  {row,col} of the current cursor, for display.
- cursor_valid  out  1  combinational; the board cell under the cursor is empty.

Behaviour:
- Reset values:
  - state = LOCKED.
  - cursor = {BOARD_N/2, BOARD_N/2}, i.e. (4,4) at default.
  - move_out = 0, move_ready = 0, is_pass = 0, locked = 1.
- Button inputs: all six are registered once into btn_q, then again into btn_d. Event = btn_q & ~btn_d. Holding a button produces exactly one event.
- Event priority within one cycle: pass > make_move > up > down > left > right. Lower-priority events in that cycle are dropped.
- Row index increases downward: up = row-1, down = row+1. Column index increases rightward: left = col-1, right = col+1.
- State LOCKED:
  - locked = 1; all events ignored.
  - my_turn high → IDLE. If the cell under the cursor is occupied on entry, start a SEEK rightward.
- State IDLE:
  - pass event → COMMIT with move_out = PASS_CODE, is_pass = 1.
  - make_move event with cursor_valid = 1 → COMMIT with move_out = cursor, is_pass = 0.
  - make_move event with cursor_valid = 0 → ignored; stay in IDLE.
  - direction event → latch seek_dir, latch seek_start = cursor, step once → SEEK.
- State SEEK: one step per cycle along seek_dir; step_cnt counts steps taken.
  - Stop when the cell under the cursor is empty → IDLE.
  - WRAP=1: coordinate BOARD_N-1 +1 → 0, and 0 -1 → BOARD_N-1. After BOARD_N-1 steps with no empty cell, restore cursor = seek_start → IDLE.
  - WRAP=0: at the edge, no further step is possible. If no empty cell was found, restore cursor = seek_start → IDLE.
  - Events that arrive during SEEK are dropped.
- State COMMIT:
  - move_ready = 1 for exactly one cycle → DONE.
  - move_out and is_pass hold their values until the next COMMIT or reset.
- State DONE:
  - locked = 1.
  - Waits for my_turn low → LOCKED. This prevents a double commit if the engine is slow to drop my_turn.
- my_turn low in IDLE or SEEK → LOCKED on the next edge. A SEEK that is interrupted restores cursor = seek_start.
- my_turn low in COMMIT: move_ready still pulses.
- Latency: make_move first sampled high at edge k. btn_q updates at edge k, the event is visible in cycle k→k+1, and move_ready is high for the cycle k+2→k+3. Pass has the same latency.
- Full board: no empty cells. SEEK always restores seek_start, cursor_valid = 0, and only a pass can commit.
- Reset mid-operation: reset returns all state to the reset values, including btn_q and btn_d (cleared to 0).

Decomposition:
- Package go_pkg holds:
  - cell_t enum: EMPTY = 2'b00, BLACK = 2'b01, WHITE = 2'b10.
  - dir_t enum: UP, DOWN, LEFT, RIGHT.
  - ui_state_t enum: LOCKED, IDLE, SEEK, COMMIT, DONE.
  - PASS_CODE constant.
  - cell_at(board, r, c) function.
- Sub-module btn_edge #(W): double register plus rising-edge detect for W inputs. Instantiated once with W = 6.

Test Plan:
- Empty board, reset, my_turn = 1, make_move pressed → one move_ready pulse, move_out = 8'h44, is_pass = 0, locked = 0 afterwards until DONE.
- Cells (4,5) and (4,6) occupied, cursor (4,4), right pressed → cursor passes through (4,5) and (4,6), settles at (4,7) after 3 SEEK cycles.
- WRAP=1, cursor (4,8), right pressed → cursor = (4,0). WRAP=0, same stimulus → cursor stays (4,8).
- Row 0 fully occupied except (0,4), cursor (0,4), left pressed → cursor restored to (0,4) after 8 steps.
- pass_btn and make_move pressed in the same cycle → move_out = 8'hFF, is_pass = 1, exactly one pulse.
- my_turn held high after commit, make_move pressed again → no second pulse.
- my_turn dropped mid-SEEK → locked = 1 and cursor = seek_start on the next cycle.
